// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a shared add/subtract unit.
// One operation in flight: IDLE grants, EXEC computes, RESP presents.
module addsub_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_m,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_m,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_ovf,
   output logic             res_id,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t           state;
   logic             last;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             m_q;
   logic             id_q;
   logic             gnt0;
   logic             gnt1;
   logic [WIDTH-1:0] bx;
   logic [WIDTH:0]   full;

   // last holds the requester served most recently; the other one wins a tie
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE) begin
         gnt0 = req0_valid & (~req1_valid | last);
         gnt1 = req1_valid & (~req0_valid | ~last);
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   assign bx   = b_q ^ {WIDTH{m_q}};
   assign full = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, m_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         a_q       <= '0;
         b_q       <= '0;
         m_q       <= 1'b0;
         id_q      <= 1'b0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_ovf   <= 1'b0;
         res_id    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (gnt0 | gnt1) begin
                  a_q   <= gnt1 ? req1_a : req0_a;
                  b_q   <= gnt1 ? req1_b : req0_b;
                  m_q   <= gnt1 ? req1_m : req0_m;
                  id_q  <= gnt1;
                  busy  <= 1'b1;
                  state <= EXEC;
               end
            end
            EXEC: begin
               res_sum   <= full[WIDTH-1:0];
               res_cout  <= full[WIDTH];
               res_ovf   <= (a_q[WIDTH-1] == bx[WIDTH-1]) &
                            (full[WIDTH-1] != a_q[WIDTH-1]);
               res_id    <= id_q;
               res_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  last      <= res_id;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: arithmetic reference model plus directed
// vectors with literal expected results.
module tb_addsub_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid, req0_ready, req0_m;
   logic [3:0] req0_a, req0_b;
   logic       req1_valid, req1_ready, req1_m;
   logic [3:0] req1_a, req1_b;
   logic       res_valid, res_ready, res_cout, res_ovf, res_id, busy;
   logic [3:0] res_sum;

   int total = 0;
   int bad   = 0;
   int lat;

   addsub_arbiter #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_m(req0_m),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_m(req1_m),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
      .res_id(res_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, want, $time);
      end
   endtask

   // reference model: plain integer arithmetic
   function automatic logic [5:0] alu(input logic [3:0] a, input logic [3:0] b,
                                      input bit m);
      int ua, ub, sa, sb, r, sr;
      bit c, o;
      logic [3:0] s;
      ua = a;
      ub = b;
      sa = (ua > 7) ? ua - 16 : ua;
      sb = (ub > 7) ? ub - 16 : ub;
      if (m) begin
         r = ua - ub; c = (ua >= ub); sr = sa - sb;
      end else begin
         r = ua + ub; c = (r > 15); sr = sa + sb;
      end
      o = (sr > 7) || (sr < -8);
      s = r[3:0];
      return {c, o, s};
   endfunction

   bit         mon = 0;
   int         age = -1;
   bit         served = 1;
   logic [3:0] e_sum, pa, pb;
   bit         e_cout, e_ovf, e_id, e_valid, pm, pid;

   function automatic bit erdy(input bit id);
      if (!mon || age >= 0) return 1'b0;
      if (!id) return req0_valid && (!req1_valid || served);
      return req1_valid && (!req0_valid || !served);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mon = 1; age = -1; served = 1; e_valid = 0;
         e_sum = 0; e_cout = 0; e_ovf = 0; e_id = 0;
      end else if (mon) begin
         if (age >= 1) begin
            if (res_ready) begin
               served = e_id; age = -1; e_valid = 0;
            end
         end else if (age == 0) begin
            {e_cout, e_ovf, e_sum} = alu(pa, pb, pm);
            e_id = pid; e_valid = 1; age = 1;
         end else if (erdy(1'b0)) begin
            pa = req0_a; pb = req0_b; pm = req0_m; pid = 0; age = 0;
         end else if (erdy(1'b1)) begin
            pa = req1_a; pb = req1_b; pm = req1_m; pid = 1; age = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (mon) begin
         chk("m_rdy0", req0_ready, erdy(1'b0));
         chk("m_rdy1", req1_ready, erdy(1'b1));
         chk("m_busy", busy, age >= 0);
         chk("m_valid", res_valid, e_valid);
         chk("m_sum", res_sum, e_sum);
         chk("m_cout", res_cout, e_cout);
         chk("m_ovf", res_ovf, e_ovf);
         chk("m_id", res_id, e_id);
      end
   end

   task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b,
                        input bit m);
      int n;
      if (id) begin
         req1_valid = 1; req1_a = a; req1_b = b; req1_m = m;
      end else begin
         req0_valid = 1; req0_a = a; req0_b = b; req0_m = m;
      end
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (id ? req1_ready : req0_ready) break;
         @(posedge clk); #1;
      end
      if (n == 20) chk("issue_timeout", 0, 1);
      @(posedge clk); #1;
      if (id) req1_valid = 0; else req0_valid = 0;
   endtask

   task automatic wait_res(output int l);
      l = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         l++;
         if (res_valid) return;
      end
      chk("wait_res_timeout", 0, 1);
   endtask

   task automatic expect_res(input string nm, input int s, input int c,
                             input int o, input int id);
      chk({nm, "_valid"}, res_valid, 1);
      chk({nm, "_sum"}, res_sum, s);
      chk({nm, "_cout"}, res_cout, c);
      chk({nm, "_ovf"}, res_ovf, o);
      chk({nm, "_id"}, res_id, id);
   endtask

   initial begin
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_m = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_m = 0;
      res_ready = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sum", res_sum, 0);
      chk("rst_flags", {res_cout, res_ovf, res_id}, 0);
      @(posedge clk); #1;

      issue(0, 4'b1010, 4'b1100, 0);
      wait_res(lat);
      chk("lat_add", lat, 2);
      expect_res("r0_add", 4'b0110, 1, 1, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("retired", res_valid, 0);
      @(posedge clk); #1;

      issue(1, 4'b1111, 4'b1010, 1);
      wait_res(lat);
      expect_res("r1_sub", 4'b0101, 1, 0, 1);
      @(posedge clk); #1;
      issue(1, 4'b1000, 4'b0100, 0);
      wait_res(lat);
      expect_res("r1_add", 4'b1100, 0, 0, 1);
      @(posedge clk); #1;

      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      req0_valid = 1; req0_a = 4'b1010; req0_b = 4'b0110; req0_m = 1;
      req1_valid = 1; req1_a = 4'b1001; req1_b = 4'b0100; req1_m = 1;
      for (int k = 0; k < 4; k++) begin
         wait_res(lat);
         chk("rr_lat", lat, 3);
         if (k % 2 == 0) expect_res("rr0", 4'b0100, 1, 1, 0);
         else expect_res("rr1", 4'b0101, 1, 1, 1);
         @(posedge clk); #1;
      end
      req0_valid = 0; req1_valid = 0;
      @(posedge clk); #1;

      res_ready = 0;
      issue(0, 4'b0011, 4'b0100, 0);
      wait_res(lat);
      chk("stall_lat", lat, 2);
      expect_res("stall", 4'b0111, 0, 0, 0);
      @(posedge clk); #1;
      req0_valid = 1; req0_a = 4'b0001; req0_b = 4'b0001; req0_m = 0;
      repeat (5) begin
         @(negedge clk);
         expect_res("stall_hold", 4'b0111, 0, 0, 0);
         chk("stall_rdy", {req0_ready, req1_ready}, 0);
         chk("stall_busy", busy, 1);
         @(posedge clk); #1;
      end
      req0_valid = 0;
      res_ready = 1;
      @(negedge clk);
      chk("stall_last", res_valid, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_retired", res_valid, 0);
      @(posedge clk); #1;

      issue(1, 4'b0111, 4'b0001, 0);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("exec_rst_valid", res_valid, 0);
      chk("exec_rst_busy", busy, 0);
      chk("exec_rst_sum", res_sum, 0);
      repeat (5) begin
         @(negedge clk);
         chk("no_stale", res_valid, 0);
      end
      @(posedge clk); #1;

      res_ready = 0;
      issue(0, 4'b0110, 4'b0011, 1);
      wait_res(lat);
      expect_res("pulse_first", 4'b0011, 1, 0, 0);
      @(posedge clk); #1;
      req1_valid = 1; req1_a = 4'b0111; req1_b = 4'b1111; req1_m = 1;
      req0_valid = 1;
      @(posedge clk); #1;
      req0_valid = 0;
      @(posedge clk); #1;
      res_ready = 1;
      @(posedge clk); #1;
      wait_res(lat);
      chk("pulse_lat", lat, 3);
      expect_res("pulse_r1", 4'b1000, 0, 1, 1);
      @(posedge clk); #1;
      req1_valid = 0;
      repeat (3) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
